fb_write_ctrl: RTL and testbench
================================

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 320, horizontal pixels.
REQ-002 SHALL have parameter V_RES, default 240, vertical pixels; FB_DEPTH = H_RES*V_RES (76800).
REQ-003 SHALL have parameter ADDR_W, default 17, framebuffer address width.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe: UART receiver byte available.
REQ-007 SHALL have port rx_data  input  8  received byte, valid when rx_valid=1.
REQ-008 SHALL have port fb_grant  input  1  framebuffer write port free this cycle (VGA scanout has priority).
REQ-009 SHALL have port fb_we  output  1  framebuffer write enable.
REQ-010 SHALL have port fb_addr  output  ADDR_W  framebuffer write address.
REQ-011 SHALL have port fb_wdata  output  7  pixel value written.
REQ-012 SHALL have port busy  output  1  pending byte held or clear in progress.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse on last-address write.
REQ-014 SHALL have port overflow  output  1  sticky: a byte was dropped.

Function
REQ-015 SHALL decode bytes: bit7=0 -> pixel, value rx_data[6:0]; 0b10xxxxxx -> SYNC; 0b11cccccc -> CLEAR, fill = {1'b0,cccccc}.
REQ-016 SHALL hold one pending byte; byte accepted when rx_valid=1 and pending empty and state IDLE.
REQ-017 SHALL drop the byte and set overflow when rx_valid=1 while pending full or state CLEAR; overflow clears only on reset.
REQ-018 SHALL have states IDLE and CLEAR only.
REQ-019 IDLE, pending pixel: SHALL assert fb_we only in a cycle with fb_grant=1, fb_addr=wr_addr, fb_wdata=pixel; pending empties that cycle.
REQ-020 Pixel latency: accepted at edge t -> fb_we earliest in cycle t+1; each cycle with fb_grant=0 adds one cycle.
REQ-021 SHALL increment wr_addr after each pixel write; at FB_DEPTH-1 SHALL wrap to 0 and pulse frame_done in the same cycle as that write.
REQ-022 Pending SYNC: SHALL set wr_addr=0 on the next edge independent of fb_grant, no write, no frame_done.
REQ-023 Pending CLEAR: SHALL enter CLEAR with clr_addr=0 and latch fill value; pending empties.
REQ-024 CLEAR: each fb_grant=1 cycle SHALL write fill at clr_addr, then increment; fb_we=0 when fb_grant=0.
REQ-025 CLEAR write at FB_DEPTH-1: SHALL pulse frame_done, set wr_addr=0, return to IDLE next cycle.
REQ-026 fb_we SHALL never be 1 while fb_grant=0.
REQ-027 busy SHALL equal (pending full) OR (state==CLEAR); a new byte may be accepted the cycle after busy falls.
REQ-028 rx_valid with pending empty in the same cycle a write retires SHALL be accepted (no bubble required by retire).
REQ-029 fb_addr and fb_wdata SHALL be don't-care when fb_we=0 but SHALL not contain X after reset.

Reset
REQ-030 On rst=0 SHALL asynchronously: state=IDLE, pending empty, wr_addr=0, clr_addr=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, frame_done=0, overflow=0.
REQ-031 Reset mid-CLEAR or with pending pixel SHALL abort without further writes; first byte after release handled as from power-up.

Verification
REQ-032 Reset, fb_grant=1, bytes 0x80,0x12,0x34 -> writes (addr 0,0x12),(addr 1,0x34); no overflow.
REQ-033 fb_grant=0 for 5 cycles after pixel 0x56 accepted -> fb_we stays 0, write at addr held appears on first grant cycle; second byte during hold -> dropped, overflow=1.
REQ-034 Write 76800 pixels after SYNC -> frame_done one pulse on addr 76799 write; next pixel writes addr 0.
REQ-035 Send 0xC5 with fb_grant toggling 1/0 -> 76800 writes of 0x05 at addr 0..76799 in order, frame_done once, busy low after; byte during CLEAR -> overflow=1.
REQ-036 Assert rst=0 mid-CLEAR at clr_addr 1000 -> fb_we=0 immediately, all outputs at reset values; post-release 0x80,0x11 -> write addr 0 value 0x11.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl
//   Turns a stream of UART bytes into framebuffer writes.
//     0xxxxxxx : pixel, value = byte[6:0], written at the running write address
//     10xxxxxx : SYNC, running write address returns to 0
//     11cccccc : CLEAR, fill the whole framebuffer with {1'b0, cccccc}
//   One byte can be held pending. The framebuffer write port is shared with
//   scanout, so a write only happens in a cycle where fb_grant is high.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   rx_valid   : one-cycle strobe, rx_data holds a received byte
//   rx_data    : received byte
//   fb_grant   : framebuffer write port is free this cycle
//   fb_we      : framebuffer write enable (only ever high with fb_grant)
//   fb_addr    : framebuffer write address
//   fb_wdata   : pixel value written
//   busy       : a byte is pending or a clear is running
//   frame_done : one-cycle pulse alongside the write to the last address
//   overflow   : sticky, a received byte was dropped
// -----------------------------------------------------------------------------
module fb_write_ctrl #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              fb_grant,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [6:0]        fb_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                FB_DEPTH  = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_reg,      state_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [7:0]        pend_byte_reg,  pend_byte_next;
  logic [ADDR_W-1:0] wr_addr_reg,    wr_addr_next;
  logic [ADDR_W-1:0] clr_addr_reg,   clr_addr_next;
  logic [6:0]        fill_reg,       fill_next;
  logic              overflow_reg,   overflow_next;
  logic              accept;

  // A byte is only taken when nothing is pending and no clear is running;
  // anything else arriving is lost and flagged.
  assign accept = rx_valid && !pend_valid_reg && (state_reg == ST_IDLE);

  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_byte_next  = pend_byte_reg;
    wr_addr_next    = wr_addr_reg;
    clr_addr_next   = clr_addr_reg;
    fill_next       = fill_reg;
    overflow_next   = overflow_reg;
    fb_we           = 1'b0;
    fb_addr         = wr_addr_reg;
    fb_wdata        = pend_byte_reg[6:0];
    frame_done      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pend_valid_reg) begin
          if (!pend_byte_reg[7]) begin
            // Pixel: waits in pending until the port is granted.
            if (fb_grant) begin
              fb_we           = 1'b1;
              pend_valid_next = 1'b0;
              if (wr_addr_reg == LAST_ADDR) begin
                wr_addr_next = '0;
                frame_done   = 1'b1;
              end else begin
                wr_addr_next = wr_addr_reg + ADDR_ONE;
              end
            end
          end else if (!pend_byte_reg[6]) begin
            // SYNC needs no port access, so it retires regardless of grant.
            wr_addr_next    = '0;
            pend_valid_next = 1'b0;
          end else begin
            state_next      = ST_CLEAR;
            clr_addr_next   = '0;
            fill_next       = {1'b0, pend_byte_reg[5:0]};
            pend_valid_next = 1'b0;
          end
        end
      end

      ST_CLEAR: begin
        fb_addr  = clr_addr_reg;
        fb_wdata = fill_reg;
        if (fb_grant) begin
          fb_we = 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            frame_done    = 1'b1;
            wr_addr_next  = '0;
            clr_addr_next = '0;
            state_next    = ST_IDLE;
          end else begin
            clr_addr_next = clr_addr_reg + ADDR_ONE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // accept implies pending is empty, so this never collides with a retire.
    if (accept) begin
      pend_valid_next = 1'b1;
      pend_byte_next  = rx_data;
    end
    if (rx_valid && !accept) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      pend_valid_reg <= 1'b0;
      pend_byte_reg  <= '0;
      wr_addr_reg    <= '0;
      clr_addr_reg   <= '0;
      fill_reg       <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_byte_reg  <= pend_byte_next;
      wr_addr_reg    <= wr_addr_next;
      clr_addr_reg   <= clr_addr_next;
      fill_reg       <= fill_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign busy     = pend_valid_reg || (state_reg == ST_CLEAR);
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_write_ctrl
//   Scoreboard bench for fb_write_ctrl. Accepted bytes are turned into the
//   list of framebuffer writes they should cause (address, value, frame_done)
//   and queued; a monitor pops one entry per observed write. A reduced frame
//   size keeps full-frame and clear runs short.
// -----------------------------------------------------------------------------
module tb_fb_write_ctrl;

  localparam int H_RES  = 40;
  localparam int V_RES  = 30;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = H_RES * V_RES;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              fb_grant = 1'b0;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [6:0]        fb_wdata;
  logic              busy;
  logic              frame_done;
  logic              overflow;

  fb_write_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .fb_grant   (fb_grant),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [6:0]        data;
    logic              fd;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_addr = 0;      // reference running write address
  int  grant_mode = 1;  // 0 random, 1 always, 2 toggle, 3 never

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: what writes a byte causes once it has been accepted.
  function automatic void model_byte(input logic [7:0] b);
    if (!b[7]) begin
      exp_q.push_back('{addr: ADDR_W'(m_addr), data: b[6:0], fd: (m_addr == DEPTH - 1)});
      m_addr = (m_addr + 1) % DEPTH;
    end else if (!b[6]) begin
      m_addr = 0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back('{addr: ADDR_W'(i), data: {1'b0, b[5:0]}, fd: (i == DEPTH - 1)});
      m_addr = 0;
    end
  endfunction

  // Grant driver, updated after the stimulus driver so a mode change applies
  // to the same cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (grant_mode)
        0:       fb_grant = 1'($urandom_range(0, 1));
        1:       fb_grant = 1'b1;
        2:       fb_grant = ~fb_grant;
        default: fb_grant = 1'b0;
      endcase
    end
  end

  // Monitor: one scoreboard entry per observed write.
  always @(negedge clk) begin
    if (rst) begin
      if (fb_we) begin
        check("we_needs_grant", 32'(fb_grant), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected", fb_addr, fb_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e.addr));
          check("wr_data", 32'(fb_wdata), 32'(e.data));
          check("frame_done", 32'(frame_done), 32'(e.fd));
          if (e.fd || (e.addr % 300 == 0))
            $display("write addr %0d data 0x%0h frame_done %0b", fb_addr, fb_wdata, frame_done);
        end
      end else if (frame_done) begin
        check("frame_done_without_write", 32'(frame_done), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  // Asserts reset wherever the caller is in the cycle, then releases it.
  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset released");
  endtask

  // Waits for all expected writes, then one settling cycle, then busy must be low.
  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d writes still outstanding", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Called just after a rising edge; sends one byte that must be accepted.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    $display("byte 0x%02h sent", b);
    wait_idle();
  endtask

  initial begin
    logic [7:0] b;

    // Power-up reset
    @(posedge clk);
    #1;
    do_reset();

    // Basic sequence with the port always granted
    grant_mode = 1;
    send(8'h80);
    send(8'h12);
    send(8'h34);
    check("no_overflow_basic", 32'(overflow), 32'd0);

    // Random pixels and syncs with random grant and random gaps
    grant_mode = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) b = {2'b10, 6'($urandom)};
      else                           b = {1'b0, 7'($urandom)};
      send(b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    check("no_overflow_random", 32'(overflow), 32'd0);

    // Back-to-back: a new byte in the cycle right after busy falls
    grant_mode = 1;
    for (int i = 0; i < 20; i++) begin
      b = {1'b0, 7'($urandom)};
      rx_valid = 1'b1;
      rx_data  = b;
      model_byte(b);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_idle();
    check("no_overflow_b2b", 32'(overflow), 32'd0);

    // Full frame after SYNC, then one more pixel wraps to address 0
    grant_mode = 0;
    send(8'h80);
    for (int i = 0; i < DEPTH + 1; i++) send({1'b0, 7'($urandom)});
    check("no_overflow_frame", 32'(overflow), 32'd0);

    // CLEAR with toggling grant; a byte during the clear is dropped
    grant_mode = 2;
    rx_valid = 1'b1;
    rx_data  = 8'hC5;
    model_byte(8'hC5);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'h23;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("overflow_during_clear", 32'(overflow), 32'd1);
    check("busy_during_clear", 32'(busy), 32'd1);
    wait_idle();
    send(8'h44);  // lands at address 0 after the clear
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Held pixel without grant; second byte while held is dropped
    @(posedge clk);
    #1;
    do_reset();
    send(8'h01);
    grant_mode = 3;
    rx_valid = 1'b1;
    rx_data  = 8'h56;
    model_byte(8'h56);
    @(posedge clk);
    #1;
    rx_data = 8'h77;
    @(negedge clk);
    check("hold_no_we", 32'(fb_we), 32'd0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("overflow_on_hold", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_no_we", 32'(fb_we), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    grant_mode = 1;
    wait_idle();

    // Reset in the middle of a CLEAR, around clr_addr 1000
    @(posedge clk);
    #1;
    do_reset();
    grant_mode = 1;
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    model_byte(8'hC3);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!(exp_q.size() > 0 && exp_q[0].addr == ADDR_W'(1001)) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 5000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL clear_progress_timeout: clear did not reach address 1000");
      end
    end
    #2;
    do_reset();
    repeat (5) @(posedge clk);  // no stray writes may follow the aborted clear
    #1;
    check("post_abort_busy", 32'(busy), 32'd0);
    send(8'h80);
    send(8'h11);
    check("post_abort_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
